// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking of digit_en when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_en
);
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state;
    logic [BIN_W-1:0]     bin_sr;
    logic [4*DIGITS-1:0]  scratch;
    logic [4*DIGITS-1:0]  corrected;
    logic [4*DIGITS-1:0]  shifted;
    logic [CW-1:0]        cnt;

    // DIGITS must cover ceil(BIN_W*log10(2)); integer form of that bound.
    if (BIN_W < 1 || BIN_W > 32 || DIGITS * 100000 < BIN_W * 30103) begin : g_param_check
        $error("bin2bcd_seq: BIN_W must be 1..32 and DIGITS >= ceil(BIN_W*0.30103)");
    end

    always_comb begin
        corrected = scratch;
        for (int i = 0; i < DIGITS; i++)
            corrected[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
    end

    assign shifted = {corrected[4*DIGITS-2:0], bin_sr[BIN_W-1]};

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] en_next;
    logic              hi;

    // Scan from the most significant digit down; units digit always lit.
    always_comb begin
        hi      = 1'b0;
        en_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi         = hi | (|shifted[4*i+:4]);
            en_next[i] = hi | (i == 0);
        end
    end
`else
    assign digit_en = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
`ifdef BIN2BCD_BLANK_EN
            digit_en <= DIGITS'(1);
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    bin_sr  <= bin_in;
                    scratch <= '0;
                    cnt     <= CW'(BIN_W);
                    busy    <= 1'b1;
                    state   <= SHIFT;
                end
            end else begin
                scratch <= shifted;
                bin_sr  <= bin_sr << 1;
                cnt     <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    bcd_out <= shifted;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
`ifdef BIN2BCD_BLANK_EN
                    digit_en <= en_next;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq at 8/3 and 16/5 configurations.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start16 = 1'b0;
    logic [7:0]  bin = '0;
    logic [15:0] bin16 = '0;
    logic        busy, done, busy16, done16;
    logic [11:0] bcd;
    logic [19:0] bcd16;
    logic [2:0]  den;
    logic [4:0]  den16;
    int          checks = 0;
    int          failures = 0;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [2:0] DEN_RST = 3'b001;
    localparam logic [4:0] DEN16_RST = 5'b00001;
`else
    localparam logic [2:0] DEN_RST = 3'b111;
    localparam logic [4:0] DEN16_RST = 5'b11111;
`endif

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin),
        .busy(busy), .done(done), .bcd_out(bcd), .digit_en(den)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .bin_in(bin16),
        .busy(busy16), .done(done16), .bcd_out(bcd16), .digit_en(den16)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref8(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] en8(input int v);
`ifdef BIN2BCD_BLANK_EN
        return v >= 100 ? 3'b111 : v >= 10 ? 3'b011 : 3'b001;
`else
        return 3'b111;
`endif
    endfunction

    // Runs one 8-bit conversion from the IDLE state and records what was observed.
    task automatic conv8(input logic [7:0] v, output logic [11:0] r, output logic [2:0] e,
                         output int lat, output int bcnt, output int nd);
        bin = v;
        start = 1'b1;
        lat = -1;
        nd = 0;
        r = '0;
        e = '0;
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = int'(busy);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            bcnt += int'(busy);
            if (done) begin
                nd++;
                lat = k;
                r = bcd;
                e = den;
            end
        end
    endtask

    task automatic conv16(input logic [15:0] v, output logic [19:0] r, output logic [4:0] e,
                          output int lat, output int bcnt);
        bin16 = v;
        start16 = 1'b1;
        lat = -1;
        r = '0;
        e = '0;
        @(posedge clk); #1;
        start16 = 1'b0;
        bcnt = int'(busy16);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            bcnt += int'(busy16);
            if (done16) begin
                lat = k;
                r = bcd16;
                e = den16;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || den !== DEN_RST) begin
            failures++;
            $display("FAIL reset8: busy=%b done=%b bcd=%h den=%b, need 0 0 000 %b", busy, done, bcd, den, DEN_RST);
        end
        checks++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || bcd16 !== 20'h00000 || den16 !== DEN16_RST) begin
            failures++;
            $display("FAIL reset16: busy=%b done=%b bcd=%h den=%b, need 0 0 00000 %b", busy16, done16, bcd16, den16, DEN16_RST);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_max;
        logic [11:0] r;
        logic [2:0]  e;
        int          lat, bcnt, nd;
        conv8(8'd255, r, e, lat, bcnt, nd);
        checks++;
        if (r !== 12'h255 || e !== en8(255)) begin
            failures++;
            $display("FAIL max_value: bcd=%h den=%b, need 255 %b", r, e, en8(255));
        end
        checks++;
        if (lat != 8 || bcnt != 8 || nd != 1) begin
            failures++;
            $display("FAIL max_timing: done_at=%0d busy_cycles=%0d dones=%0d, need 8 8 1", lat, bcnt, nd);
        end
    endtask

    // Asynchronous reset while idle clears the held 255 result without a clock edge.
    task automatic test_reset_idle;
        rst = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || den !== DEN_RST) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b bcd=%h den=%b, need 0 0 000 %b", busy, done, bcd, den, DEN_RST);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [11:0] r1, r2, mid;
        logic [2:0]  e1, e2;
        int          t1, t2, nd;
        r1 = '1; r2 = '1; mid = '1; e1 = '0; e2 = '0; t1 = -1; t2 = -1; nd = 0;
        bin = 8'd99;
        start = 1'b1;
        @(posedge clk); #1;
        bin = 8'd0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            if (k == 12) mid = bcd;
            if (done) begin
                nd++;
                if (nd == 1) begin
                    t1 = k; r1 = bcd; e1 = den;
                end else begin
                    t2 = k; r2 = bcd; e2 = den;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (r1 !== 12'h099 || e1 !== en8(99) || t1 != 8) begin
            failures++;
            $display("FAIL b2b_first: bcd=%h den=%b at=%0d, need 099 %b 8", r1, e1, t1, en8(99));
        end
        checks++;
        if (mid !== 12'h099) begin
            failures++;
            $display("FAIL b2b_hold: bcd=%h during second conversion, need 099", mid);
        end
        checks++;
        if (r2 !== 12'h000 || e2 !== en8(0) || t2 - t1 != 9 || nd != 2) begin
            failures++;
            $display("FAIL b2b_second: bcd=%h den=%b gap=%0d dones=%0d, need 000 %b 9 2", r2, e2, t2 - t1, nd, en8(0));
        end
    endtask

    task automatic test_ignore_busy;
        logic [11:0] r;
        int          lat, nd;
        r = '0; lat = -1; nd = 0;
        bin = 8'd128;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++; lat = k; r = bcd;
            end
            if (k == 3) begin
                start = 1'b1; bin = 8'd7;
            end
            if (k == 4) start = 1'b0;
        end
        checks++;
        if (r !== 12'h128 || nd != 1 || lat != 8) begin
            failures++;
            $display("FAIL ignore_busy: bcd=%h dones=%0d at=%0d, need 128 1 8", r, nd, lat);
        end
    endtask

    task automatic test_abort;
        logic [11:0] r;
        logic [2:0]  e;
        int          lat, bcnt, nd;
        bin = 8'd200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || den !== DEN_RST) begin
            failures++;
            $display("FAIL abort_reset: busy=%b done=%b bcd=%h den=%b, need 0 0 000 %b", busy, done, bcd, den, DEN_RST);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        checks++;
        if (nd != 0 || bcd !== 12'h000) begin
            failures++;
            $display("FAIL abort_quiet: active_cycles=%0d bcd=%h, need 0 000", nd, bcd);
        end
        conv8(8'd45, r, e, lat, bcnt, nd);
        checks++;
        if (r !== 12'h045 || e !== en8(45) || lat != 8 || nd != 1) begin
            failures++;
            $display("FAIL abort_restart: bcd=%h den=%b at=%0d dones=%0d, need 045 %b 8 1", r, e, lat, nd, en8(45));
        end
    endtask

    task automatic test_wide;
        logic [19:0] r;
        logic [4:0]  e;
        int          lat, bcnt;
        conv16(16'd65535, r, e, lat, bcnt);
        checks++;
        if (r !== 20'h65535 || e !== 5'b11111 || lat != 16 || bcnt != 16) begin
            failures++;
            $display("FAIL wide_max: bcd=%h den=%b at=%0d busy=%0d, need 65535 11111 16 16", r, e, lat, bcnt);
        end
        conv16(16'd10000, r, e, lat, bcnt);
        checks++;
        if (r !== 20'h10000 || e !== 5'b11111 || lat != 16) begin
            failures++;
            $display("FAIL wide_10000: bcd=%h den=%b at=%0d, need 10000 11111 16", r, e, lat);
        end
    endtask

    task automatic test_sweep;
        logic [11:0] r;
        logic [2:0]  e;
        int          lat, bcnt, nd;
        for (int v = 0; v < 256; v++) begin
            conv8(8'(v), r, e, lat, bcnt, nd);
            checks++;
            if (r !== ref8(v) || e !== en8(v) || lat != 8 || nd != 1) begin
                failures++;
                $display("FAIL sweep %0d: bcd=%h den=%b at=%0d dones=%0d, need %h %b 8 1", v, r, e, lat, nd, ref8(v), en8(v));
            end
        end
    endtask

    initial begin
        test_reset;
        test_max;
        test_reset_idle;
        test_back_to_back;
        test_ignore_busy;
        test_abort;
        test_wide;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Processes one bit per clock and holds BIN_W bits of input.
- Replaces chains of combinational add-3 cells with a single row of DIGITS correction cells, reused every cycle.
- Sits between counters/datapath registers and the 7-segment display driver.

Parameters:
- BIN_W, 8: width of the unsigned binary input, 1..32.
- DIGITS, 3: number of BCD output digits. Must be >= ceil(BIN_W*0.30103). Elaboration fails (generate-time error) if smaller.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: bcd_out has just been updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]; registered.
- digit_en  output  DIGITS  per-digit display enable (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, busy=0, done=0, bcd_out=0.
  - digit_en = all ones without the macro; only bit 0 set with the macro.
  - Internal shift register and bit counter cleared.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with start=1: load bin_in into the binary shift register, clear the BCD scratch register, bit counter=BIN_W, busy<=1, go to SHIFT.
  - done is low in IDLE except during the pulse cycle.
- SHIFT, each edge:
  - Combinationally, every scratch digit with value >=5 gets +3 (4-bit, no carry out).
  - Then the concatenation {scratch, binary} shifts left by 1; binary MSB enters scratch bit 0.
  - Counter decrements.
  - On the edge where counter goes 1->0: bcd_out<=corrected-and-shifted scratch, done<=1, busy<=0, digit_en updated, state=IDLE.
- Latency: start sampled at edge E0 -> shifts on edges E1..E_BIN_W -> done high for the cycle after edge E_BIN_W. busy is high for exactly BIN_W cycles.
- Digit correction invariant: scratch digits always stay within 0..9 after each shift.
- Boundary conditions:
  - start while busy=1: ignored, no queuing.
  - bin_in changes during SHIFT: no effect.
  - start=1 in the done cycle: accepted, since state is IDLE. New conversion begins; bcd_out keeps the previous result until its own done.
  - start held continuously: back-to-back conversions, one every BIN_W+1 cycles.
  - rst asserted mid-conversion: immediate abort, all outputs to reset values, no done pulse.
  - bin_in=0: bcd_out=0 after full latency (no early exit).
  - Max input (2^BIN_W-1): exact result, no truncation, given the DIGITS rule.
- bcd_out and digit_en change only on the done edge or on reset.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined:
  - digit_en[i]=1 iff digit i is nonzero, or any higher digit is nonzero, or i=0.
  - Leading zeros are blanked; units digit is always enabled.
  - Computed at result-load time and registered alongside bcd_out.
- Undefined: digit_en is tied to all ones; no blanking logic is synthesised.

Test Plan:
- Reset: assert rst mid-idle -> busy=0, done=0, bcd_out=12'h000, digit_en=3'b111 (3'b001 with macro).
- BIN_W=8, DIGITS=3: start with bin_in=8'd255 -> busy for 8 cycles, done pulse one cycle, bcd_out=12'h255. With macro, digit_en=3'b111.
- bin_in=8'd99 then bin_in=8'd0 back-to-back, start held high -> first done gives 12'h099, second done 9 cycles later gives 12'h000. With macro, digit_en is 3'b011 then 3'b001.
- Start with bin_in=8'd128; pulse start again and change bin_in to 8'd7 on cycle 3 of busy -> ignored; bcd_out=12'h128, exactly one done pulse.
- Start with bin_in=8'd200; assert rst on cycle 4 -> no done pulse, bcd_out stays 12'h000. After release, start with 8'd45 -> 12'h045.
- BIN_W=16, DIGITS=5: bin_in=16'd65535 -> done after 16 cycles, bcd_out=20'h65535. bin_in=16'd10000 -> 20'h10000. Sweep all 0..255 at BIN_W=8 against a reference model.
